// File: rtl/unary_add_n_if.sv
// Unary lane bundle: input pulses, downstream ready and the serial output pulse.
// Handshake: a unit moves on dout exactly when the cycle that produced it had dout_ready=1 in emit mode.
interface unary_add_n_if #(
  parameter int NUM_IN = 2
);
  logic [NUM_IN-1:0] din;
  logic              dout_ready;
  logic              dout;

  modport master (
    output din,
    output dout_ready,
    input  dout
  );

  modport slave (
    input  din,
    input  dout_ready,
    output dout
  );
endinterface

// File: rtl/unary_add_n.sv
// N-lane unary accumulator that counts input pulses, then replays the total as a
// serial unary pulse train under a ready handshake, with wrap or saturate overflow.
module unary_add_n #(
  parameter int NUM_IN   = 2,
  parameter int CNT_W    = 3,
  parameter int CARRY_W  = 4,
  parameter int SAT_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               mode,
  unary_add_n_if.slave       bus,
  output logic               carry,
  output logic [CARRY_W-1:0] carry_cnt,
  output logic               sat_flag,
  output logic [CNT_W-1:0]   count,
  output logic               done
);

  logic [CNT_W:0]   pop;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] count_nxt;
  logic             emit_unit;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pop = pop + (CNT_W+1)'(bus.din[i]);
    end
  end

  // One extra bit so the overflow (wrap or clip) is visible in sum[CNT_W].
  assign sum       = {1'b0, count} + pop;
  assign emit_unit = mode && bus.dout_ready && (count != '0);

  always_comb begin
    count_nxt = count;
    if (!mode) begin
      if ((SAT_MODE != 0) && sum[CNT_W]) begin
        count_nxt = '1;
      end else begin
        count_nxt = sum[CNT_W-1:0];
      end
    end else if (emit_unit) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      carry_cnt <= '0;
      bus.dout  <= 1'b0;
      carry     <= 1'b0;
      sat_flag  <= 1'b0;
      done      <= 1'b0;
    end else if (clr) begin
      count     <= '0;
      carry_cnt <= '0;
      bus.dout  <= 1'b0;
      carry     <= 1'b0;
      sat_flag  <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Pulses default low; they are only raised on an enabled cycle below.
      bus.dout <= 1'b0;
      carry    <= 1'b0;
      if (en) begin
        count <= count_nxt;
        done  <= mode && (count_nxt == '0);
        if (!mode) begin
          if ((SAT_MODE == 0) && sum[CNT_W]) begin
            carry     <= 1'b1;
            carry_cnt <= carry_cnt + CARRY_W'(1);
          end
          if ((SAT_MODE != 0) && sum[CNT_W]) begin
            sat_flag <= 1'b1;
          end
        end else if (emit_unit) begin
          bus.dout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_unary_add_n.sv
// Directed bench for unary_add_n: one wrap-mode and one saturate-mode instance
// driven in lockstep with hand-computed expectations.
module tb_unary_add_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] din = '0;
  logic       dout_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic       carry_w, carry_s, sat_w, sat_s, done_w, done_s;
  logic [3:0] ccnt_w, ccnt_s;
  logic [2:0] count_w, count_s;

  unary_add_n_if #(.NUM_IN(3)) if_w ();
  unary_add_n_if #(.NUM_IN(3)) if_s ();

  assign if_w.din        = din;
  assign if_w.dout_ready = dout_ready;
  assign if_s.din        = din;
  assign if_s.dout_ready = dout_ready;

  unary_add_n #(.NUM_IN(3), .CNT_W(3), .CARRY_W(4), .SAT_MODE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .bus(if_w.slave),
    .carry(carry_w), .carry_cnt(ccnt_w), .sat_flag(sat_w), .count(count_w), .done(done_w)
  );

  unary_add_n #(.NUM_IN(3), .CNT_W(3), .CARRY_W(4), .SAT_MODE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .bus(if_s.slave),
    .carry(carry_s), .carry_cnt(ccnt_s), .sat_flag(sat_s), .count(count_s), .done(done_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w"}, {carry_w, sat_w, done_w, if_w.dout, ccnt_w, count_w}, 0);
    check({tag, "_s"}, {carry_s, sat_s, done_s, if_s.dout, ccnt_s, count_s}, 0);
  endtask

  logic [6:0] bp_ready;
  logic [6:0] bp_dout;
  logic [2:0] bp_count [7];
  logic [6:0] bp_done;

  initial begin
    // Reset with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      en = 1'b1;
      mode = 1'($urandom_range(0, 1));
      din = 3'($urandom_range(0, 7));
      dout_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check_all_zero("reset");
    en = 1'b0; mode = 1'b0; din = 3'b111; dout_ready = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    check_all_zero("idle_en0");

    // Wrap vs saturate with din=111.
    en = 1'b1;
    tick();
    check("acc1_cnt_w", count_w, 3); check("acc1_cnt_s", count_s, 3); check("acc1_carry", carry_w, 0);
    tick();
    check("acc2_cnt_w", count_w, 6); check("acc2_cnt_s", count_s, 6); check("acc2_carry", carry_w, 0);
    tick();
    check("acc3_cnt_w", count_w, 1); check("acc3_carry_w", carry_w, 1); check("acc3_ccnt_w", ccnt_w, 1);
    check("acc3_cnt_s", count_s, 7); check("acc3_sat_s", sat_s, 1); check("acc3_carry_s", carry_s, 0);
    check("acc3_sat_w", sat_w, 0);
    din = 3'b000;
    tick();
    check("hold_carry_w", carry_w, 0); check("hold_ccnt_w", ccnt_w, 1); check("hold_cnt_w", count_w, 1);
    tick();
    check("hold_sat_s", sat_s, 1); check("hold_cnt_s", count_s, 7);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_all_zero("clr1");

    // Emit 5 units.
    din = 3'b111; tick();
    din = 3'b011; tick();
    check("pre_emit_cnt", count_w, 5);
    din = 3'b111; mode = 1'b1; dout_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("emit_dout", if_w.dout, 1);
      check("emit_cnt", count_w, 5 - k);
      check("emit_done", done_w, (k == 5) ? 1 : 0);
    end
    tick();
    check("emit_end_dout", if_w.dout, 0); check("emit_end_done", done_w, 1); check("emit_end_cnt", count_w, 0);
    check("emit_carry", carry_w, 0);

    // Backpressure with count=4.
    clr = 1'b1; tick(); clr = 1'b0;
    mode = 1'b0; dout_ready = 1'b0;
    din = 3'b111; tick();
    din = 3'b001; tick();
    check("bp_pre_cnt", count_w, 4);
    mode = 1'b1;
    bp_ready = 7'b1011001;
    bp_dout  = 7'b1011001;
    bp_done  = 7'b1000000;
    bp_count = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd1, 3'd0};
    for (int k = 0; k < 7; k++) begin
      dout_ready = bp_ready[k];
      tick();
      check("bp_dout", if_w.dout, bp_dout[k]);
      check("bp_cnt", count_w, bp_count[k]);
      check("bp_done", done_w, bp_done[k]);
    end
    dout_ready = 1'b1;
    tick();
    check("bp_tail_dout", if_w.dout, 0); check("bp_tail_cnt", count_w, 0); check("bp_tail_done", done_w, 1);

    // clr during emit with count=6.
    clr = 1'b1; tick(); clr = 1'b0;
    mode = 1'b0; din = 3'b111; tick(); tick();
    check("clr_pre_cnt", count_w, 6);
    mode = 1'b1; dout_ready = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_emit_cnt", count_w, 0); check("clr_emit_dout", if_w.dout, 0); check("clr_emit_done", done_w, 0);
    tick();
    check("clr_after_done", done_w, 1); check("clr_after_dout", if_w.dout, 0);

    // en=0 mid-accumulate.
    mode = 1'b0; din = 3'b111; tick();
    check("en_acc_cnt", count_w, 3); check("en_acc_done", done_w, 0);
    en = 1'b0; tick(); tick();
    check("en0_cnt_w", count_w, 3); check("en0_cnt_s", count_s, 3); check("en0_carry", carry_w, 0);
    en = 1'b1; tick();
    check("en1_cnt", count_w, 6);

    // en=0 in emit: dout low, done holds.
    mode = 1'b1; dout_ready = 1'b1; tick();
    check("em_dout", if_w.dout, 1); check("em_cnt", count_w, 5);
    en = 1'b0; tick();
    check("em_en0_dout", if_w.dout, 0); check("em_en0_cnt", count_w, 5); check("em_en0_done", done_w, 0);

    // Asynchronous reset mid-emit, away from a clock edge.
    en = 1'b1; tick();
    check("pre_rst_dout", if_w.dout, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unary_add_n.md
Name: unary_add_n

Overview:
- Parametrised, N-input successor to the 2-input unary serial adder.
- Accumulate phase: each cycle, counts the 1-pulses present on NUM_IN unary input lanes.
- Emit phase: plays the accumulated total back as a serial unary pulse train on dout, under a ready handshake.
- Adds over the previous generation: selectable wrap/saturate overflow handling, a carry counter, a sticky saturation flag, synchronous clear, output backpressure and a done indication.
- Sits between unary stream sources and downstream unary consumers in the stochastic/unary datapath.

Parameters:
- NUM_IN, 2: number of unary input lanes; legal range 1 .. 2^CNT_W-1.
- CNT_W, 3: accumulator width; accumulator modulus is 2^CNT_W.
- CARRY_W, 4: width of the wrap-event counter.
- SAT_MODE, 0: 0 = wrap on overflow with carry pulse; 1 = saturate at 2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  global cycle enable; when low, all state holds.
- clr  input  1  synchronous clear; has priority over en.
- mode  input  1  0 = accumulate (read), 1 = emit (write).
- din  input  NUM_IN  unary input pulses, one bit per lane.
- dout_ready  input  1  downstream accepts a unit this cycle.
- dout  output  1  registered unary output pulse.
- carry  output  1  one-cycle pulse on a wrap (SAT_MODE=0 only).
- carry_cnt  output  CARRY_W  number of wraps since reset/clr; wraps modulo 2^CARRY_W.
- sat_flag  output  1  sticky; set when a sum was clipped (SAT_MODE=1 only).
- count  output  CNT_W  current accumulator value.
- done  output  1  registered; high while mode=1 and count==0.

Behaviour:
- Reset (rst_n low, async): count, carry_cnt, dout, carry, sat_flag and done all = 0. Reset asserted mid-accumulate or mid-emit aborts immediately; no partial output.
- clr=1 at a clock edge: same values as reset, regardless of en or mode.
- Pulses: dout and carry are single-cycle; they read 0 on any cycle they are not explicitly set, including en=0 cycles.
- en=0: count, carry_cnt, sat_flag and done hold; dout=0 and carry=0.
- Accumulate (en=1, mode=0):
  - p = popcount(din), range 0..NUM_IN; sum = count + p, computed at CNT_W+1 bits.
  - SAT_MODE=0: count <= sum[CNT_W-1:0]. If sum[CNT_W]=1, carry=1 next cycle and carry_cnt increments. At most one wrap per cycle, guaranteed by NUM_IN < 2^CNT_W.
  - SAT_MODE=1: if sum > 2^CNT_W-1, count <= 2^CNT_W-1 and sat_flag <= 1 (sticky). Otherwise count <= sum. carry stays 0.
  - dout=0 throughout accumulate.
- Emit (en=1, mode=1):
  - dout_ready=1 and count!=0: dout <= 1, count <= count-1.
  - dout_ready=1 and count==0: dout <= 0.
  - dout_ready=0: dout <= 0, count holds (stall; no unit lost).
  - din is ignored; carry=0.
- Totals: total dout pulses emitted equals count at emit entry, one cycle of latency from each accepted ready cycle.
- done: registered as (mode==1 && count_next==0). It therefore rises on the same edge the final dout=1 is issued, or one cycle after entering emit with count=0.
- Mode switching: allowed on any cycle. count carries across (partial emit then resume accumulate continues from the remaining count). carry_cnt and sat_flag are unaffected by mode.
- No internal FSM beyond mode. All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, idle with en=0 -> outputs stay 0.
- Wrap (NUM_IN=3, CNT_W=3, SAT_MODE=0), din=111 for 3 cycles -> count 3, 6, 1; carry=1 exactly on the third-cycle result; carry_cnt=1.
- Saturate (SAT_MODE=1), same stimulus -> count 3, 6, 7; sat_flag=1 and remains 1 with further din=000 until clr.
- Emit: accumulate to count=5, then mode=1 with dout_ready=1 -> dout=1 for exactly 5 consecutive cycles; count 4..0; done=1 from the 5th pulse cycle onward.
- Backpressure: count=4, dout_ready pattern 1,0,0,1,1,0,1 -> dout=1 only on the four ready cycles; count never underflows; done after the 4th pulse.
- clr/en: clr during emit with count=6 -> next cycle count=0, dout=0, done reflects count 0. en=0 mid-accumulate with din=111 -> count unchanged.
